// File: rtl/fixed_point_pkg.sv
// Shared helpers for the fixed-point mean-square stage: saturation limits and
// the widths of the squared sample and the window accumulator.
package fixed_point_pkg;

  function automatic logic [63:0] fp_sat_max(input int wi, input int wf);
    return (64'd1 << (wi + wf - 1)) - 64'd1;
  endfunction

  function automatic int sq_width(input int w);
    return 2 * w;
  endfunction

  // N squares of 2w bits each fit in 2w+log2n bits, so the sum never wraps.
  function automatic int acc_width(input int w, input int log2n);
    return 2 * w + log2n;
  endfunction

endpackage

// File: rtl/comb_FixedPointZoom.sv
// Combinational signed fixed-point reformatter: Q(WII).(WIF) -> Q(WOI).(WOF)
// with optional round-half-up and saturation, flagging out-of-range results.
module comb_FixedPointZoom
  import fixed_point_pkg::*;
#(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter bit ROOF  = 1'b1,
  parameter bit ROUND = 1'b1
) (
  input  logic [WII+WIF-1:0] in,
  output logic [WOI+WOF-1:0] out,
  output logic               upflow,
  output logic               downflow
);

  localparam int WIN = WII + WIF;
  localparam int WT  = WII + WOF + 1;  // one spare integer bit absorbs the rounding carry
  localparam int WO  = WOI + WOF;

  logic signed [WT-1:0] tmp;

  generate
    if (WIF > WOF) begin : g_drop
      localparam int D = WIF - WOF;
      localparam logic signed [WIN:0] HALF = ROUND ? ((WIN+1)'(1) << (D - 1)) : {(WIN+1){1'b0}};
      logic signed [WIN:0] ext;
      always_comb begin
        ext = $signed({in[WIN-1], in}) + HALF;
        tmp = WT'(ext >>> D);
      end
    end else if (WIF == WOF) begin : g_keep
      always_comb tmp = $signed({in[WIN-1], in});
    end else begin : g_pad
      always_comb tmp = $signed({in[WIN-1], in, {(WOF-WIF){1'b0}}});
    end

    if (WT > WO) begin : g_narrow
      localparam logic signed [WT-1:0] MAXV = WT'(fp_sat_max(WOI, WOF));
      localparam logic signed [WT-1:0] MINV = ~MAXV;
      always_comb begin
        upflow   = (tmp > MAXV);
        downflow = (tmp < MINV);
        if (ROOF && upflow) begin
          out = MAXV[WO-1:0];
        end else if (ROOF && downflow) begin
          out = MINV[WO-1:0];
        end else begin
          out = tmp[WO-1:0];
        end
      end
    end else begin : g_wide
      always_comb begin
        upflow   = 1'b0;
        downflow = 1'b0;
        out      = WO'(tmp);
      end
    end
  endgenerate

endmodule

// File: rtl/fixed_point_mean_square.sv
// Streaming mean of squares over windows of 2**LOG2N valid samples; the result
// feeds a fixed-point square root so that sqrt(out) is the window RMS.
module fixed_point_mean_square
  import fixed_point_pkg::*;
#(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int LOG2N = 2,
  parameter bit ROOF  = 1'b1,
  parameter bit ROUND = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 clr,
  input  logic [WII+WIF-1:0]   in,
  output logic                 o_en,
  output logic [WOI+WOF-1:0]   out,
  output logic                 upflow
);

  localparam int W    = WII + WIF;
  localparam int SQW  = sq_width(W);
  localparam int ACCW = acc_width(W, LOG2N);
  localparam int WO   = WOI + WOF;
  localparam logic [LOG2N:0] LAST = (LOG2N+1)'((1 << LOG2N) - 1);

  logic [W-1:0]    mag;
  logic [SQW-1:0]  sq;
  logic            v1;
  logic            c1;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] base_acc;
  logic [ACCW-1:0] sum;
  logic [LOG2N:0]  cnt;
  logic [LOG2N:0]  base_cnt;
  logic [SQW-1:0]  mean;
  logic            m_v;
  logic [2*W:0]    zoom_in;
  logic [WO-1:0]   zoom_out;
  logic            zoom_up;
  logic            downflow_unused;

  // |in| as unsigned; the most negative input maps to 2^(W-1) without overflow.
  always_comb mag = in[W-1] ? (~in + W'(1)) : in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sq <= {SQW{1'b0}};
      v1 <= 1'b0;
      c1 <= 1'b0;
    end else begin
      sq <= SQW'(mag) * SQW'(mag);
      v1 <= i_en;
      c1 <= clr;
    end
  end

  // A clear restarts the window underneath the sample arriving with it.
  always_comb begin
    base_acc = c1 ? {ACCW{1'b0}} : acc;
    base_cnt = c1 ? {(LOG2N+1){1'b0}} : cnt;
    sum      = base_acc + ACCW'(sq);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc  <= {ACCW{1'b0}};
      cnt  <= {(LOG2N+1){1'b0}};
      mean <= {SQW{1'b0}};
      m_v  <= 1'b0;
    end else begin
      m_v <= 1'b0;
      if (v1 && (base_cnt == LAST)) begin
        mean <= SQW'(sum >> LOG2N);
        m_v  <= 1'b1;
        acc  <= {ACCW{1'b0}};
        cnt  <= {(LOG2N+1){1'b0}};
      end else if (v1) begin
        acc <= sum;
        cnt <= base_cnt + (LOG2N+1)'(1);
      end else begin
        acc <= base_acc;
        cnt <= base_cnt;
      end
    end
  end

  // The mean is non-negative, so a zero sign bit makes it a valid signed word.
  always_comb zoom_in = {1'b0, mean};

  comb_FixedPointZoom #(
    .WII   (2 * WII + 1),
    .WIF   (2 * WIF),
    .WOI   (WOI),
    .WOF   (WOF),
    .ROOF  (ROOF),
    .ROUND (ROUND)
  ) u_zoom (
    .in       (zoom_in),
    .out      (zoom_out),
    .upflow   (zoom_up),
    .downflow (downflow_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_en   <= 1'b0;
      out    <= {WO{1'b0}};
      upflow <= 1'b0;
    end else begin
      o_en   <= m_v;
      out    <= zoom_out;
      upflow <= zoom_up;
    end
  end

endmodule

// File: tb/tb_fixed_point_mean_square.sv
// Bench for fixed_point_mean_square (Q8.8, N=4, rounding); a saturating and a
// wrapping instance share the same stimulus.
module tb_fixed_point_mean_square;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic        clr;
  logic [15:0] in;
  logic        o_en, upflow, o_en_w, upflow_w;
  logic [15:0] out, out_w;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int last_edge;

  int          q_edge[$];
  logic [15:0] q_out[$];
  logic        q_up[$];
  logic [15:0] q_out_w[$];
  logic        q_up_w[$];

  fixed_point_mean_square #(.ROOF(1'b1)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .clr(clr), .in(in),
    .o_en(o_en), .out(out), .upflow(upflow)
  );

  fixed_point_mean_square #(.ROOF(1'b0)) dut_w (
    .clk(clk), .rst(rst), .i_en(i_en), .clr(clr), .in(in),
    .o_en(o_en_w), .out(out_w), .upflow(upflow_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (o_en) begin
      q_edge.push_back(edge_cnt);
      q_out.push_back(out);
      q_up.push_back(upflow);
    end
    if (o_en_w) begin
      q_out_w.push_back(out_w);
      q_up_w.push_back(upflow_w);
    end
  end

  // Reference: mean of squares in Q.16, rounded half-up to Q.8, then saturated or wrapped.
  function automatic logic [16:0] model(input longint sum_sq, input bit roof);
    longint      mean;
    longint      r;
    logic [15:0] lo;
    bit          up;
    mean = sum_sq / 4;
    r    = (mean + 128) / 256;
    lo   = r[15:0];
    up   = (r > 32767);
    if (roof && up) lo = 16'h7FFF;
    return {up, lo};
  endfunction

  function automatic longint sqr(input logic [15:0] x);
    longint v;
    v = longint'($signed(x));
    return v * v;
  endfunction

  task automatic send(input logic en, input logic c, input logic [15:0] x);
    i_en = en; clr = c; in = x;
    @(posedge clk); #1;
    last_edge = edge_cnt;
    i_en = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic flush_queues();
    q_edge.delete(); q_out.delete(); q_up.delete(); q_out_w.delete(); q_up_w.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b0; i_en = 1'b0; clr = 1'b0; in = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b1;
    flush_queues();
  endtask

  task automatic test_reset();
    rst = 1'b0; i_en = 1'b0; clr = 1'b0; in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_en !== 1'b0) begin n_fail++; $display("FAIL reset_o_en got %b want 0", o_en); end
    n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got %h want 0000", out); end
    n_checks++; if (upflow !== 1'b0) begin n_fail++; $display("FAIL reset_upflow got %b want 0", upflow); end
    rst = 1'b1;
    flush_queues();
  endtask

  task automatic test_unit();
    int e;
    reset_dut();
    repeat (4) send(1'b1, 1'b0, 16'h0100);
    e = last_edge;
    idle(8);
    n_checks++; if (q_out.size() !== 1) begin n_fail++; $display("FAIL unit_count got %0d want 1", q_out.size()); end
    if (q_out.size() > 0) begin
      n_checks++; if (q_out[0] !== 16'h0100) begin n_fail++; $display("FAIL unit_out got %h want 0100", q_out[0]); end
      n_checks++; if (q_up[0] !== 1'b0) begin n_fail++; $display("FAIL unit_up got %b want 0", q_up[0]); end
      n_checks++; if (q_edge[0] !== e + 2) begin n_fail++; $display("FAIL unit_latency got edge %0d want %0d", q_edge[0], e + 2); end
    end
  endtask

  task automatic test_gaps();
    logic [15:0] s [4];
    s = '{16'h0200, 16'hFE00, 16'h0000, 16'h0000};
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 3));
      send(1'b1, 1'b0, s[i]);
    end
    idle(6);
    n_checks++; if (q_out.size() !== 1) begin n_fail++; $display("FAIL gaps_count got %0d want 1", q_out.size()); end
    if (q_out.size() > 0) begin
      n_checks++; if (q_out[0] !== 16'h0200) begin n_fail++; $display("FAIL gaps_out got %h want 0200", q_out[0]); end
    end
  endtask

  task automatic test_half();
    reset_dut();
    repeat (4) send(1'b1, 1'b0, 16'h0080);
    idle(6);
    n_checks++; if (q_out.size() !== 1) begin n_fail++; $display("FAIL half_count got %0d want 1", q_out.size()); end
    if (q_out.size() > 0) begin
      n_checks++; if (q_out[0] !== 16'h0040) begin n_fail++; $display("FAIL half_out got %h want 0040", q_out[0]); end
    end
  endtask

  task automatic test_saturate();
    reset_dut();
    repeat (4) send(1'b1, 1'b0, 16'h1000);
    repeat (4) send(1'b1, 1'b0, 16'h8000);
    idle(6);
    n_checks++; if (q_out.size() !== 2) begin n_fail++; $display("FAIL sat_count got %0d want 2", q_out.size()); end
    n_checks++; if (q_out_w.size() !== 2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", q_out_w.size()); end
    for (int i = 0; i < 2; i++) begin
      if (q_out.size() > i) begin
        n_checks++; if (q_out[i] !== 16'h7FFF) begin n_fail++; $display("FAIL sat_out[%0d] got %h want 7fff", i, q_out[i]); end
        n_checks++; if (q_up[i] !== 1'b1) begin n_fail++; $display("FAIL sat_up[%0d] got %b want 1", i, q_up[i]); end
      end
      if (q_out_w.size() > i) begin
        n_checks++; if (q_out_w[i] !== 16'h0000) begin n_fail++; $display("FAIL wrap_out[%0d] got %h want 0000", i, q_out_w[i]); end
        n_checks++; if (q_up_w[i] !== 1'b1) begin n_fail++; $display("FAIL wrap_up[%0d] got %b want 1", i, q_up_w[i]); end
      end
    end
  endtask

  task automatic test_clr_idle();
    reset_dut();
    repeat (2) send(1'b1, 1'b0, 16'h0300);
    send(1'b0, 1'b1, 16'h0000);
    repeat (4) send(1'b1, 1'b0, 16'h0100);
    idle(6);
    n_checks++; if (q_out.size() !== 1) begin n_fail++; $display("FAIL clr_idle_count got %0d want 1", q_out.size()); end
    if (q_out.size() > 0) begin
      n_checks++; if (q_out[0] !== 16'h0100) begin n_fail++; $display("FAIL clr_idle_out got %h want 0100", q_out[0]); end
    end
  endtask

  task automatic test_clr_valid();
    reset_dut();
    send(1'b1, 1'b0, 16'h0500);
    send(1'b1, 1'b1, 16'h0100);
    repeat (3) send(1'b1, 1'b0, 16'h0100);
    idle(6);
    n_checks++; if (q_out.size() !== 1) begin n_fail++; $display("FAIL clr_valid_count got %0d want 1", q_out.size()); end
    if (q_out.size() > 0) begin
      n_checks++; if (q_out[0] !== 16'h0100) begin n_fail++; $display("FAIL clr_valid_out got %h want 0100", q_out[0]); end
    end
  endtask

  task automatic test_clr_after_nth();
    reset_dut();
    repeat (4) send(1'b1, 1'b0, 16'h0100);
    send(1'b0, 1'b1, 16'h0000);
    idle(6);
    n_checks++; if (q_out.size() !== 1) begin n_fail++; $display("FAIL clr_late_count got %0d want 1", q_out.size()); end
    if (q_out.size() > 0) begin
      n_checks++; if (q_out[0] !== 16'h0100) begin n_fail++; $display("FAIL clr_late_out got %h want 0100", q_out[0]); end
    end
  endtask

  task automatic test_mid_reset();
    reset_dut();
    repeat (4) send(1'b1, 1'b0, 16'h0300);
    idle(4);
    repeat (3) send(1'b1, 1'b0, 16'h0300);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (o_en !== 1'b0) begin n_fail++; $display("FAIL midrst_o_en got %b want 0", o_en); end
    n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL midrst_out got %h want 0000", out); end
    n_checks++; if (upflow !== 1'b0) begin n_fail++; $display("FAIL midrst_up got %b want 0", upflow); end
    rst = 1'b1;
    flush_queues();
    repeat (4) send(1'b1, 1'b0, 16'h0200);
    idle(6);
    n_checks++; if (q_out.size() !== 1) begin n_fail++; $display("FAIL postrst_count got %0d want 1", q_out.size()); end
    if (q_out.size() > 0) begin
      n_checks++; if (q_out[0] !== 16'h0400) begin n_fail++; $display("FAIL postrst_out got %h want 0400", q_out[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] smp [64];
    int          e_last [16];
    longint      sum;
    logic [16:0] exp_s, exp_w;
    reset_dut();
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) smp[i] = 16'($urandom);
      else smp[i] = 16'($signed(17'($urandom_range(0, 16'h1600)) - 17'h00B00));
      send(1'b1, 1'b0, smp[i]);
      if (i % 4 == 3) e_last[i / 4] = last_edge;
    end
    idle(6);
    n_checks++; if (q_out.size() !== 16) begin n_fail++; $display("FAIL b2b_count got %0d want 16", q_out.size()); end
    for (int w = 0; w < 16; w++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) sum += sqr(smp[4 * w + k]);
      exp_s = model(sum, 1'b1);
      exp_w = model(sum, 1'b0);
      if (q_out.size() > w) begin
        n_checks++; if ({q_up[w], q_out[w]} !== exp_s) begin n_fail++; $display("FAIL b2b_sat[%0d] got %b/%h want %b/%h", w, q_up[w], q_out[w], exp_s[16], exp_s[15:0]); end
        n_checks++; if (q_edge[w] !== e_last[w] + 2) begin n_fail++; $display("FAIL b2b_edge[%0d] got %0d want %0d", w, q_edge[w], e_last[w] + 2); end
      end
      if (q_out_w.size() > w) begin
        n_checks++; if ({q_up_w[w], q_out_w[w]} !== exp_w) begin n_fail++; $display("FAIL b2b_wrap[%0d] got %b/%h want %b/%h", w, q_up_w[w], q_out_w[w], exp_w[16], exp_w[15:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_gaps();
    test_half();
    test_saturate();
    test_clr_idle();
    test_clr_valid();
    test_clr_after_nth();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
